mult_port_rr_memory: RTL

Parametrised multi-port front end for one single-port `sram_wrapper`.
- Each of `PORT_NUM` ports has a one-entry request holding register and a one-entry read-response register, using the valid/busy handshake.
- A round-robin arbiter grants one port per cycle.
- Byte-masked writes are supported by an internal read-modify-write (RMW) sequence.
- Read data is returned on a per-port data bus instead of a shared one.

---
 rtl/mult_port_mem_pkg.sv | 27 ++
 rtl/mult_port_rr_memory_arbiter.sv | 45 ++++
 rtl/sram_wrapper.sv | 37 +++
 rtl/mult_port_rr_memory.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_port_mem_pkg.sv
// ------------------------------------------------------------------
// mult_port_mem_pkg: shared types for the multi-port SRAM front end
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mult_port_mem_pkg;

  localparam int REQ_ADDR_WIDTH = 8;
  localparam int REQ_DATA_WIDTH = 64;
  localparam int MASK_WIDTH     = REQ_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    RMW_WR = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                      write;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [REQ_DATA_WIDTH-1:0] data;
    logic [MASK_WIDTH-1:0]     mask;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mult_port_rr_memory_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter: one-hot round-robin grant, search starts after last winner
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q, last_d;
  logic          found;

  always_comb begin
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (enable && !found && req[(int'(last_q) + i) % N]) begin
        grant[(int'(last_q) + i) % N] = 1'b1;
        last_d = IW'((int'(last_q) + i) % N);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_wrapper.sv
// ------------------------------------------------------------------
// sram_wrapper: single-port synchronous SRAM, one-cycle read latency
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_wrapper #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Macro model: array and read register carry no reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        mem_q[addr] <= d;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign q = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mult_port_rr_memory.sv
// ------------------------------------------------------------------
// mult_port_rr_memory: PORT_NUM request/response ports arbitrated onto one SRAM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mult_port_rr_memory
  import mult_port_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = REQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = REQ_DATA_WIDTH,
  parameter int PORT_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORT_NUM-1:0]            din_valid,
  output logic [PORT_NUM-1:0]            din_busy,
  input  logic [PORT_NUM-1:0]            din_write_req,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] din_addr,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] din_data,
  input  logic [PORT_NUM*DATA_WIDTH/8-1:0] din_mask,
  output logic [PORT_NUM-1:0]            dout_valid,
  input  logic [PORT_NUM-1:0]            dout_busy,
  output logic [PORT_NUM*DATA_WIDTH-1:0] dout_data,
  output logic [PORT_NUM-1:0]            wr_done
);

  localparam int MW = DATA_WIDTH / 8;
  localparam int PW = $clog2(PORT_NUM);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [MW-1:0]         mask;
  } port_req_t;

  port_req_t             req_arr [PORT_NUM];
  port_req_t             g_req;
  logic [PW-1:0]         gsel;
  logic [PORT_NUM-1:0]   eligible, grant;
  logic [PORT_NUM-1:0]   rd_pend_q, rd_pend_d, wr_done_q, wr_done_d;
  logic [PORT_NUM-1:0]   rmw_port_q, rmw_port_d;
  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_WIDTH-1:0] rmw_data_q, rmw_data_d, rmw_bmask, merge;
  logic [MW-1:0]         rmw_mask_q, rmw_mask_d;
  logic                  sram_ce, sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_d, sram_q;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    port_req_t             req_q, req_d;
    logic                  req_full_q, req_full_d;
    logic                  resp_full_q, resp_full_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  accept;

    // A new accept overrides the clear caused by a grant in the same cycle.
    always_comb begin
      accept      = din_valid[p] & ~din_busy[p];
      req_full_d  = req_full_q & ~grant[p];
      req_d       = req_q;
      resp_full_d = resp_full_q & dout_busy[p];
      resp_data_d = resp_data_q;
      if (accept) begin
        req_full_d  = 1'b1;
        req_d.write = din_write_req[p];
        req_d.addr  = din_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        req_d.data  = din_data[p*DATA_WIDTH +: DATA_WIDTH];
        req_d.mask  = din_mask[p*MW +: MW];
      end
      if (rd_pend_q[p]) begin
        resp_full_d = 1'b1;
        resp_data_d = sram_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req_full_q  <= 1'b0;
        req_q       <= '0;
        resp_full_q <= 1'b0;
        resp_data_q <= '0;
      end else begin
        req_full_q  <= req_full_d;
        req_q       <= req_d;
        resp_full_q <= resp_full_d;
        resp_data_q <= resp_data_d;
      end
    end

    assign req_arr[p]                         = req_q;
    assign din_busy[p]                        = req_full_q & ~grant[p];
    assign dout_valid[p]                      = resp_full_q;
    assign dout_data[p*DATA_WIDTH +: DATA_WIDTH] = resp_data_q;
    assign eligible[p] = req_full_q &
                         (req_q.write | (~rd_pend_q[p] & (~resp_full_q | ~dout_busy[p])));
  end

  rr_arbiter #(.N(PORT_NUM)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (eligible),
    .enable (state_q == ARB),
    .grant  (grant)
  );

  always_comb begin
    for (int b = 0; b < MW; b++) begin
      rmw_bmask[8*b +: 8] = {8{rmw_mask_q[b]}};
    end
  end

  assign merge = (sram_q & ~rmw_bmask) | (rmw_data_q & rmw_bmask);

  always_comb begin
    gsel = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (grant[i]) gsel = PW'(i);
    end
    g_req      = req_arr[gsel];
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = g_req.addr;
    sram_d     = g_req.data;
    state_d    = state_q;
    rd_pend_d  = '0;
    wr_done_d  = '0;
    rmw_port_d = rmw_port_q;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    rmw_mask_d = rmw_mask_q;
    case (state_q)
      ARB: begin
        if (|grant) begin
          if (!g_req.write) begin
            sram_ce   = 1'b1;
            rd_pend_d = grant;
          end else if (&g_req.mask) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            wr_done_d = grant;
          end else if (~|g_req.mask) begin
            wr_done_d = grant;
          end else begin
            // Partial mask: fetch the old word now, write the merge next cycle.
            sram_ce    = 1'b1;
            state_d    = RMW_WR;
            rmw_port_d = grant;
            rmw_addr_d = g_req.addr;
            rmw_data_d = g_req.data;
            rmw_mask_d = g_req.mask;
          end
        end
      end
      RMW_WR: begin
        sram_ce   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = rmw_addr_q;
        sram_d    = merge;
        wr_done_d = rmw_port_q;
        state_d   = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rd_pend_q  <= '0;
      wr_done_q  <= '0;
      rmw_port_q <= '0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
      rmw_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      wr_done_q  <= wr_done_d;
      rmw_port_q <= rmw_port_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
      rmw_mask_q <= rmw_mask_d;
    end
  end

  assign wr_done = wr_done_q;

  sram_wrapper #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sram (
    .clk  (clk),
    .ce   (sram_ce),
    .we   (sram_we),
    .addr (sram_addr),
    .d    (sram_d),
    .q    (sram_q)
  );

endmodule

`default_nettype wire
